// File: rtl/hps_register_bank.sv
// Avalon-MM register bank: ID, CTRL, sticky STATUS, frame counter and double-buffered config words.
// Latency: writes take effect next cycle; read data is registered one cycle after the read access.
// Backpressure: none, no waitrequest; every access completes in a single cycle.
module hps_register_bank #(
    parameter int              WIDTH_ADDR = 8,
    parameter int              WIDTH_DATA = 32,
    parameter int              WIDTH_BE   = 8,
    parameter int              NUM_CFG    = 8,
    parameter logic [31:0]     ID_VALUE   = 32'h4844_5201
) (
    input  logic                          clk_dsp,
    input  logic                          reset_n,
    input  logic                          avl_write_dsp,
    input  logic                          avl_chipselect_dsp,
    input  logic [WIDTH_ADDR-1:0]         avl_address_dsp,
    input  logic [WIDTH_BE-1:0]           avl_byteenable_dsp,
    input  logic [WIDTH_DATA-1:0]         avl_writedata_dsp,
    output logic [WIDTH_DATA-1:0]         avl_readdata_dsp,
    input  logic                          frame_start,
    input  logic                          overflow_evt,
    output logic                          ctrl_enable,
    output logic                          soft_rst_pulse,
    output logic                          update_pulse,
    output logic [NUM_CFG*WIDTH_DATA-1:0] cfg_active
);

    localparam logic [WIDTH_ADDR-1:0] ADDR_ID     = WIDTH_ADDR'(0);
    localparam logic [WIDTH_ADDR-1:0] ADDR_CTRL   = WIDTH_ADDR'(1);
    localparam logic [WIDTH_ADDR-1:0] ADDR_STATUS = WIDTH_ADDR'(2);
    localparam logic [WIDTH_ADDR-1:0] ADDR_FCNT   = WIDTH_ADDR'(3);
    localparam logic [WIDTH_ADDR-1:0] ADDR_CFG    = WIDTH_ADDR'(4);

    logic                  wr_en;
    logic                  rd_en;
    logic                  ctrl_wr;
    logic                  status_wr;
    logic                  cfg_hit;
    logic                  cfg_wr;
    logic                  apply_wr;
    logic                  transfer;
    logic [WIDTH_ADDR-1:0] cfg_off;
    logic [WIDTH_DATA-1:0] rd_mux;
    logic                  sticky_ovf;
    logic                  sticky_upd;
    logic                  pending;
    logic [31:0]           frame_cnt;
    logic [WIDTH_DATA-1:0] shadow [NUM_CFG];
    logic [WIDTH_DATA-1:0] active [NUM_CFG];
    logic                  unused_be;

    assign unused_be = &{1'b0, avl_byteenable_dsp[WIDTH_BE-1:4]};

    assign wr_en     = avl_chipselect_dsp & avl_write_dsp;
    assign rd_en     = avl_chipselect_dsp & ~avl_write_dsp;
    assign cfg_off   = avl_address_dsp - ADDR_CFG;
    assign cfg_hit   = (avl_address_dsp >= ADDR_CFG) && (int'(cfg_off) < NUM_CFG);
    assign cfg_wr    = wr_en & cfg_hit;
    assign ctrl_wr   = wr_en & (avl_address_dsp == ADDR_CTRL) & avl_byteenable_dsp[0];
    assign status_wr = wr_en & (avl_address_dsp == ADDR_STATUS) & avl_byteenable_dsp[0];
    assign apply_wr  = ctrl_wr & avl_writedata_dsp[1];
    // Frame start and apply in the same cycle collapse into a single transfer.
    assign transfer  = (frame_start & pending) | apply_wr;

    always_ff @(posedge clk_dsp or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_enable    <= 1'b0;
            soft_rst_pulse <= 1'b0;
        end else begin
            soft_rst_pulse <= ctrl_wr & avl_writedata_dsp[2];
            if (ctrl_wr) ctrl_enable <= avl_writedata_dsp[0];
        end
    end

    // Set events take priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk_dsp or negedge reset_n) begin
        if (!reset_n) begin
            sticky_ovf <= 1'b0;
            sticky_upd <= 1'b0;
        end else begin
            sticky_ovf <= overflow_evt | (sticky_ovf & ~(status_wr & avl_writedata_dsp[0]));
            sticky_upd <= update_pulse | (sticky_upd & ~(status_wr & avl_writedata_dsp[1]));
        end
    end

    always_ff @(posedge clk_dsp or negedge reset_n) begin
        if (!reset_n) frame_cnt <= '0;
        else if (frame_start) frame_cnt <= frame_cnt + 32'd1;
    end

    // Active copy samples the shadow value from before this cycle's write.
    always_ff @(posedge clk_dsp or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CFG; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            pending      <= 1'b0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= transfer;
            if (cfg_wr)        pending <= 1'b1;
            else if (transfer) pending <= 1'b0;
            for (int k = 0; k < NUM_CFG; k++) begin
                if (transfer) active[k] <= shadow[k];
                if (cfg_wr && cfg_off == WIDTH_ADDR'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (avl_byteenable_dsp[b]) shadow[k][8*b +: 8] <= avl_writedata_dsp[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avl_address_dsp)
            ADDR_ID:     rd_mux = ID_VALUE;
            ADDR_CTRL:   rd_mux = {{(WIDTH_DATA-1){1'b0}}, ctrl_enable};
            ADDR_STATUS: rd_mux = {{(WIDTH_DATA-2){1'b0}}, sticky_upd, sticky_ovf};
            ADDR_FCNT:   rd_mux = frame_cnt;
            default:     rd_mux = '0;
        endcase
        for (int k = 0; k < NUM_CFG; k++) begin
            if (cfg_hit && cfg_off == WIDTH_ADDR'(k)) rd_mux = shadow[k];
        end
    end

    always_ff @(posedge clk_dsp or negedge reset_n) begin
        if (!reset_n) avl_readdata_dsp <= '0;
        else if (rd_en) avl_readdata_dsp <= rd_mux;
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_active
        assign cfg_active[g*WIDTH_DATA +: WIDTH_DATA] = active[g];
    end

endmodule

// File: tb/tb_hps_register_bank.sv
// Directed and randomized checks of hps_register_bank against a transaction-level register model.
module tb_hps_register_bank;
    localparam int NCFG = 8;
    localparam int AW   = 8;
    localparam int CW   = NCFG * 32;
    localparam logic [31:0] ID = 32'h4844_5201;

    logic          clk_dsp = 1'b0;
    logic          reset_n = 1'b0;
    logic          we = 1'b0, cs = 1'b0, fs = 1'b0, ovf = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    be = '0;
    logic [31:0]   wd = '0;
    logic [31:0]   rdata;
    logic          ctrl_enable, soft_rst_pulse, update_pulse;
    logic [CW-1:0] cfg_active;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic        m_en, m_srp, m_upd, m_ovf, m_updst, m_pend;
    logic [31:0] m_cnt, m_rd;
    logic [31:0] m_shadow [NCFG];
    logic [31:0] m_active [NCFG];

    hps_register_bank dut (
        .clk_dsp            (clk_dsp),
        .reset_n            (reset_n),
        .avl_write_dsp      (we),
        .avl_chipselect_dsp (cs),
        .avl_address_dsp    (addr),
        .avl_byteenable_dsp (be),
        .avl_writedata_dsp  (wd),
        .avl_readdata_dsp   (rdata),
        .frame_start        (fs),
        .overflow_evt       (ovf),
        .ctrl_enable        (ctrl_enable),
        .soft_rst_pulse     (soft_rst_pulse),
        .update_pulse       (update_pulse),
        .cfg_active         (cfg_active)
    );

    always #5 clk_dsp = ~clk_dsp;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_srp = 0; m_upd = 0; m_ovf = 0; m_updst = 0; m_pend = 0;
        m_cnt = 0; m_rd = 0;
        for (int k = 0; k < NCFG; k++) begin
            m_shadow[k] = 0;
            m_active[k] = 0;
        end
    endtask

    function automatic logic [CW-1:0] exp_active();
        logic [CW-1:0] v;
        for (int k = 0; k < NCFG; k++) v[32*k +: 32] = m_active[k];
        return v;
    endfunction

    task automatic check_all();
        check("ctrl_enable", CW'(ctrl_enable), CW'(m_en));
        check("soft_rst_pulse", CW'(soft_rst_pulse), CW'(m_srp));
        check("update_pulse", CW'(update_pulse), CW'(m_upd));
        check("readdata", CW'(rdata), CW'(m_rd));
        check("cfg_active", cfg_active, exp_active());
    endtask

    // One bus cycle worth of register-map semantics, applied to the model.
    task automatic model_cycle();
        int  a;
        bit  wr, rd, ctrl_w, stat_w, apply, xfer;
        a      = int'(addr);
        wr     = cs && we;
        rd     = cs && !we;
        ctrl_w = wr && a == 1 && be[0];
        stat_w = wr && a == 2 && be[0];
        apply  = ctrl_w && wd[1];
        xfer   = (fs && m_pend) || apply;
        if (rd) begin
            if (a == 0)                       m_rd = ID;
            else if (a == 1)                  m_rd = {31'd0, m_en};
            else if (a == 2)                  m_rd = {30'd0, m_updst, m_ovf};
            else if (a == 3)                  m_rd = m_cnt;
            else if (a >= 4 && a < 4 + NCFG)  m_rd = m_shadow[a-4];
            else                              m_rd = 0;
        end
        m_ovf   = ovf || (m_ovf && !(stat_w && wd[0]));
        m_updst = m_upd || (m_updst && !(stat_w && wd[1]));
        if (xfer) for (int k = 0; k < NCFG; k++) m_active[k] = m_shadow[k];
        if (wr && a >= 4 && a < 4 + NCFG) begin
            for (int b = 0; b < 4; b++) if (be[b]) m_shadow[a-4][8*b +: 8] = wd[8*b +: 8];
            m_pend = 1;
        end else if (xfer) m_pend = 0;
        m_upd = xfer;
        m_srp = ctrl_w && wd[2];
        if (ctrl_w) m_en = wd[0];
        if (fs) m_cnt = m_cnt + 1;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk_dsp);
        #1;
        check_all();
        cs = 0; we = 0; addr = 0; be = 0; wd = 0; fs = 0; ovf = 0;
    endtask

    task automatic do_wr(input int a, input logic [7:0] b, input logic [31:0] d,
                         input logic f, input logic o);
        cs = 1; we = 1; addr = AW'(a); be = b; wd = d; fs = f; ovf = o;
        step();
    endtask

    task automatic do_rd(input int a);
        cs = 1; we = 0; addr = AW'(a);
        step();
    endtask

    task automatic idle(input logic f);
        fs = f;
        step();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(posedge clk_dsp); #1;
        reset_n = 1;

        // Identification and reset values
        do_rd(0);    check("id_read", CW'(rdata), CW'(ID));
        do_rd(1);    check("ctrl_reset", CW'(rdata), '0);
        do_rd(2);    check("status_reset", CW'(rdata), '0);
        do_rd(3);    check("fcnt_reset", CW'(rdata), '0);
        do_rd(8'hFF); check("unmapped_read", CW'(rdata), '0);

        // Byte-lane merge and frame-start transfer
        do_wr(4, 8'hF, 32'h1234_5678, 0, 0);
        do_wr(4, 8'h2, 32'hAAAA_AAAA, 0, 0);
        do_rd(4);    check("shadow_merge", CW'(rdata), CW'(32'h1234_AA78));
        check("active_before_frame", cfg_active, '0);
        idle(1);
        check("active_after_frame", CW'(cfg_active[31:0]), CW'(32'h1234_AA78));
        check("update_pulse_hi", CW'(update_pulse), CW'(1'b1));
        idle(0);
        check("update_pulse_lo", CW'(update_pulse), '0);
        do_rd(2);    check("status_upd_done", CW'(rdata[1]), CW'(1'b1));

        // CFG write coincident with frame start
        do_wr(5, 8'hF, 32'hCAFE_0001, 0, 0);
        do_wr(5, 8'hF, 32'hBEEF_0002, 1, 0);
        check("old_shadow_moved", CW'(cfg_active[63:32]), CW'(32'hCAFE_0001));
        idle(1);
        check("new_shadow_moved", CW'(cfg_active[63:32]), CW'(32'hBEEF_0002));
        idle(1);
        check("no_pending_no_pulse", CW'(update_pulse), '0);

        // Sticky overflow with simultaneous clear
        do_wr(2, 8'hF, 32'h3, 0, 1);
        do_rd(2);    check("ovf_set_wins", CW'(rdata[0]), CW'(1'b1));
        do_wr(2, 8'hF, 32'h1, 0, 0);
        do_rd(2);    check("ovf_cleared", CW'(rdata[0]), '0);

        // CTRL enable, soft reset, explicit apply
        do_wr(1, 8'h1, 32'h5, 0, 0);
        check("enable_set", CW'(ctrl_enable), CW'(1'b1));
        check("soft_rst_hi", CW'(soft_rst_pulse), CW'(1'b1));
        idle(0);
        check("soft_rst_lo", CW'(soft_rst_pulse), '0);
        do_rd(1);    check("ctrl_readback", CW'(rdata), CW'(1'b1));
        do_wr(11, 8'hF, 32'h0BAD_F00D, 0, 0);
        do_wr(1, 8'h1, 32'h2, 0, 0);
        check("apply_transfer", CW'(cfg_active[255:224]), CW'(32'h0BAD_F00D));
        check("apply_pulse", CW'(update_pulse), CW'(1'b1));

        // Frame counter wrap
        force dut.frame_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.frame_cnt;
        m_cnt = 32'hFFFF_FFFE;
        do_rd(3);    check("fcnt_preload", CW'(rdata), CW'(32'hFFFF_FFFE));
        idle(1);
        idle(1);
        do_rd(3);    check("fcnt_wrap", CW'(rdata), '0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cs   = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1) == 1;
            addr = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 13));
            be   = 8'($urandom);
            wd   = $urandom;
            fs   = ($urandom_range(0, 7) == 0);
            ovf  = ($urandom_range(0, 7) == 0);
            step();
        end

        // Asynchronous reset in the middle of traffic
        do_wr(1, 8'h1, 32'h1, 0, 0);
        cs = 1; we = 1; addr = 8'd6; be = 8'hF; wd = 32'h1111_2222; fs = 1;
        #3;
        reset_n = 0;
        #1;
        model_reset();
        check("rst_enable", CW'(ctrl_enable), '0);
        check("rst_active", cfg_active, '0);
        check_all();
        cs = 0; we = 0; fs = 0;
        @(posedge clk_dsp); #1;
        reset_n = 1;
        do_rd(6);    check("rst_shadow", CW'(rdata), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout tests=%0d", tests);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
